// File: rtl/block_pio_sequencer_pkg.sv
// Shared types for the block PIO sequencer.
// Block geometry and pixel-to-word mapping.
package compression_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  localparam int BLK_PIX   = 64;
  localparam int BLK_WORDS = 16;
  localparam int LANES     = 4;

  typedef struct packed {
    logic [3:0] word;
    logic [1:0] lane;
  } pix_loc_t;

  // row r=p/8, col c=p%8 -> word 2r+c/4, lane c%4
  function automatic pix_loc_t pix_loc(
    input logic [5:0] p
  );
    pix_loc_t l;
    l.word = {p[5:3], p[2]};
    l.lane = p[1:0];
    return l;
  endfunction

endpackage

// File: rtl/block_pio_sequencer_if.sv
// Pixel streams and CPU block handshake
// of the block PIO sequencer.
interface block_pio_sequencer_if;

  logic [7:0]   pix_in_data;
  logic         pix_in_valid;
  logic         pix_in_ready;
  logic [511:0] blk_to_cpu;
  logic [511:0] blk_from_cpu;
  logic         cpu_req;
  logic         cpu_ack;
  logic [7:0]   pix_out_data;
  logic         pix_out_valid;
  logic         pix_out_ready;

  modport master (
    input  pix_in_data,
    input  pix_in_valid,
    output pix_in_ready,
    output blk_to_cpu,
    input  blk_from_cpu,
    output cpu_req,
    input  cpu_ack,
    output pix_out_data,
    output pix_out_valid,
    input  pix_out_ready
  );

  modport slave (
    output pix_in_data,
    output pix_in_valid,
    input  pix_in_ready,
    input  blk_to_cpu,
    output blk_from_cpu,
    input  cpu_req,
    output cpu_ack,
    input  pix_out_data,
    input  pix_out_valid,
    output pix_out_ready
  );

endinterface

// File: rtl/block_word_buffer.sv
// 16x32 block store: byte write, parallel
// load, byte read, flat word view.
module block_word_buffer
  import compression_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [5:0]   wr_idx,
  input  logic [7:0]   wr_data,
  input  logic         ld_en,
  input  logic [511:0] ld_data,
  input  logic [5:0]   rd_idx,
  output logic [7:0]   rd_data,
  output logic [511:0] words
);

  logic [8*LANES-1:0] mem [BLK_WORDS];
  pix_loc_t wl;
  pix_loc_t rl;

  assign wl = pix_loc(wr_idx);
  assign rl = pix_loc(rd_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < BLK_WORDS; k++)
        mem[k] <= '0;
    end else if (ld_en) begin
      for (int k = 0; k < BLK_WORDS; k++)
        mem[k] <= ld_data[32*k +: 32];
    end else if (wr_en) begin
      mem[wl.word][{wl.lane, 3'b000} +: 8]
        <= wr_data;
    end
  end

  always_comb begin
    words = '0;
    for (int k = 0; k < BLK_WORDS; k++)
      words[32*k +: 32] = mem[k];
  end

  assign rd_data =
    mem[rl.word][{rl.lane, 3'b000} +: 8];

endmodule

// File: rtl/block_pio_sequencer.sv
// Packs 8x8 pixel blocks for the Nios II PIO
// lines, waits for results, streams them out.
module block_pio_sequencer
  import compression_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  block_pio_sequencer_if.master bus,
  output logic [7:0]           status
);

  seq_state_t  state, state_d;
  logic [6:0]  pix_cnt, pix_cnt_d;
  logic [5:0]  byte_cnt, byte_cnt_d;
  logic [4:0]  blk_cnt, blk_cnt_d;
  logic [31:0] tmo_cnt, tmo_cnt_d;
  logic        err, err_d;
  logic        in_rdy, in_rdy_d;
  logic        in_wr;
  logic        out_ld;
  logic        tmo_hit;
  logic [7:0]   unused_in_rd;
  logic [511:0] unused_out_words;

  assign in_wr = in_rdy && bus.pix_in_valid;
  assign tmo_hit = (TIMEOUT_CYCLES != 0) &&
    (tmo_cnt + 32'd1 == TIMEOUT_CYCLES);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state    <= FILL;
      pix_cnt  <= '0;
      byte_cnt <= '0;
      blk_cnt  <= '0;
      tmo_cnt  <= '0;
      err      <= 1'b0;
      in_rdy   <= 1'b0;
    end else begin
      state    <= state_d;
      pix_cnt  <= pix_cnt_d;
      byte_cnt <= byte_cnt_d;
      blk_cnt  <= blk_cnt_d;
      tmo_cnt  <= tmo_cnt_d;
      err      <= err_d;
      in_rdy   <= in_rdy_d;
    end
  end

  always_comb begin
    state_d    = state;
    pix_cnt_d  = pix_cnt;
    byte_cnt_d = byte_cnt;
    blk_cnt_d  = blk_cnt;
    tmo_cnt_d  = tmo_cnt;
    err_d      = err;
    out_ld     = 1'b0;
    unique case (state)
      FILL: begin
        if (in_wr)
          pix_cnt_d = pix_cnt + 7'd1;
        // an ack still high from the last block gates the request
        if (pix_cnt == 7'(BLK_PIX) && !bus.cpu_ack) begin
          state_d   = REQ;
          tmo_cnt_d = '0;
        end
      end
      REQ: begin
        if (bus.cpu_ack) begin
          out_ld     = 1'b1;
          byte_cnt_d = '0;
          state_d    = DRAIN;
        end else if (tmo_hit) begin
          err_d     = 1'b1;
          pix_cnt_d = '0;
          state_d   = FILL;
        end else begin
          tmo_cnt_d = tmo_cnt + 32'd1;
        end
      end
      DRAIN: begin
        if (bus.pix_out_ready) begin
          byte_cnt_d = byte_cnt + 6'd1;
          if (byte_cnt == 6'(BLK_PIX - 1)) begin
            blk_cnt_d = blk_cnt + 5'd1;
            pix_cnt_d = '0;
            state_d   = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase
    in_rdy_d = (state_d == FILL) &&
      (pix_cnt_d != 7'(BLK_PIX));
  end

  block_word_buffer u_in_buf (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .wr_en   (in_wr),
    .wr_idx  (pix_cnt[5:0]),
    .wr_data (bus.pix_in_data),
    .ld_en   (1'b0),
    .ld_data ('0),
    .rd_idx  (6'd0),
    .rd_data (unused_in_rd),
    .words   (bus.blk_to_cpu)
  );

  block_word_buffer u_out_buf (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .wr_en   (1'b0),
    .wr_idx  (6'd0),
    .wr_data (8'd0),
    .ld_en   (out_ld),
    .ld_data (bus.blk_from_cpu),
    .rd_idx  (byte_cnt),
    .rd_data (bus.pix_out_data),
    .words   (unused_out_words)
  );

  assign bus.pix_in_ready  = in_rdy;
  assign bus.cpu_req       = (state == REQ);
  assign bus.pix_out_valid = (state == DRAIN);
  assign status = {err, state, blk_cnt};

endmodule

// File: tb/tb_block_pio_sequencer.sv
// Random block traffic against a byte-level
// reference model with a scoreboarded output.
module tb_block_pio_sequencer;

  localparam int unsigned TMO = 100;

  logic       clk_clk;
  logic       reset_reset_n;
  logic [7:0] status;

  block_pio_sequencer_if bus();

  block_pio_sequencer #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .bus           (bus),
    .status        (status)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  int checks;
  int failures;
  int out_seen;
  int rdy_mode;
  int ph;
  int exp_blk_cnt;
  bit exp_err;
  logic [7:0] sb[$];

  task automatic check(
    input string        name,
    input logic [511:0] act,
    input logic [511:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
        name, act, exp);
    end
  endtask

  // downstream ready patterns
  initial begin
    ph = 0;
    bus.pix_out_ready = 1'b1;
    forever begin
      @(posedge clk_clk);
      #1;
      case (rdy_mode)
        1: begin
          bus.pix_out_ready = (ph == 0 || ph == 3);
          ph = (ph + 1) % 4;
        end
        2: bus.pix_out_ready =
             1'($urandom_range(0, 1));
        default: bus.pix_out_ready = 1'b1;
      endcase
    end
  end

  // output monitor
  initial begin
    forever begin
      @(negedge clk_clk);
      if (reset_reset_n && bus.pix_out_valid) begin
        if (!bus.pix_out_ready && sb.size() > 0)
          check("stall_data", bus.pix_out_data, sb[0]);
        if (bus.pix_out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_byte: got %0h expected none",
              bus.pix_out_data);
          end else begin
            check("out_byte", bus.pix_out_data,
              sb.pop_front());
          end
          out_seen++;
        end
      end
    end
  end

  task automatic send_pixels(
    input logic [7:0] pix[64],
    input bit         gaps
  );
    int p;
    int guard;
    bit acc;
    p = 0;
    guard = 0;
    @(posedge clk_clk);
    #1;
    while (p < 64 && guard < 5000) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.pix_in_valid = 1'b0;
      end else begin
        bus.pix_in_valid = 1'b1;
        bus.pix_in_data  = pix[p];
      end
      @(negedge clk_clk);
      acc = bus.pix_in_valid && bus.pix_in_ready;
      @(posedge clk_clk);
      #1;
      if (acc) p++;
      guard++;
    end
    bus.pix_in_valid = 1'b0;
    check("fill_count", p, 64);
  endtask

  // mode: 0 normal, 1 hold ack, 2 no ack, 3 reset mid-drain
  task automatic run_block(
    input int mode,
    input bit seq,
    input bit gaps,
    input bit ff_key,
    input int delay
  );
    logic [7:0]   pix[64];
    logic [7:0]   key[64];
    logic [511:0] exp_blk;
    logic [511:0] key_vec;
    int w, l, n, n0;
    bit held;
    exp_blk = '0;
    key_vec = '0;
    for (int p = 0; p < 64; p++) begin
      pix[p] = seq ? 8'(p) : 8'($urandom);
      key[p] = ff_key ? 8'hFF : 8'($urandom);
      w = 2 * (p / 8) + (p % 8) / 4;
      l = (p % 8) % 4;
      exp_blk[32*w + 8*l +: 8] = pix[p];
      key_vec[32*w + 8*l +: 8] = key[p];
    end
    held = bus.cpu_ack;
    send_pixels(pix, gaps);
    @(negedge clk_clk);
    check("ready_low_full", bus.pix_in_ready, 0);
    check("blk_to_cpu", bus.blk_to_cpu, exp_blk);
    if (seq) begin
      check("word0", bus.blk_to_cpu[31:0],
        32'h03020100);
      check("word15", bus.blk_to_cpu[511:480],
        32'h3F3E3D3C);
    end
    if (held) begin
      n = 0;
      repeat (10) begin
        if (bus.cpu_req) n++;
        @(negedge clk_clk);
      end
      check("req_held_off", n, 0);
      bus.cpu_ack = 1'b0;
      @(negedge clk_clk);
      check("req_after_ack_fall", bus.cpu_req, 1);
    end else begin
      check("req_not_yet", bus.cpu_req, 0);
      @(negedge clk_clk);
      check("req_rise", bus.cpu_req, 1);
    end
    if (mode == 2) begin
      n = 0;
      while (bus.cpu_req && n < 300) begin
        n++;
        @(negedge clk_clk);
      end
      check("tmo_req_cycles", n, TMO);
      exp_err = 1'b1;
      check("tmo_status", status,
        {exp_err, 2'b00, 5'(exp_blk_cnt)});
      check("tmo_ready", bus.pix_in_ready, 1);
      return;
    end
    repeat (delay) @(negedge clk_clk);
    bus.blk_from_cpu = bus.blk_to_cpu ^ key_vec;
    for (int p = 0; p < 64; p++)
      sb.push_back(pix[p] ^ key[p]);
    n0 = out_seen;
    bus.cpu_ack = 1'b1;
    @(negedge clk_clk);
    check("req_drop_on_ack", bus.cpu_req, 0);
    check("valid_on_ack", bus.pix_out_valid, 1);
    if (mode != 1) bus.cpu_ack = 1'b0;
    if (mode == 3) begin
      n = 0;
      while (out_seen < n0 + 20 && n < 500) begin
        @(negedge clk_clk);
        n++;
      end
      check("reach_byte20", out_seen >= n0 + 20, 1);
      @(posedge clk_clk);
      #2;
      reset_reset_n = 1'b0;
      #1;
      check("rst_req", bus.cpu_req, 0);
      check("rst_valid", bus.pix_out_valid, 0);
      check("rst_data", bus.pix_out_data, 0);
      check("rst_ready", bus.pix_in_ready, 0);
      check("rst_status", status, 0);
      check("rst_blk", bus.blk_to_cpu, 0);
      sb.delete();
      exp_blk_cnt = 0;
      exp_err = 1'b0;
      repeat (3) @(negedge clk_clk);
      reset_reset_n = 1'b1;
      @(negedge clk_clk);
      check("ready_after_rst", bus.pix_in_ready, 1);
      n = 0;
      repeat (20) begin
        if (bus.pix_out_valid) n++;
        @(negedge clk_clk);
      end
      check("no_residual", n, 0);
      return;
    end
    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk_clk);
      n++;
    end
    check("drain_done", sb.size(), 0);
    @(negedge clk_clk);
    exp_blk_cnt = (exp_blk_cnt + 1) % 32;
    check("status", status,
      {exp_err, 2'b00, 5'(exp_blk_cnt)});
    check("valid_low", bus.pix_out_valid, 0);
    check("blk_hold", bus.blk_to_cpu, exp_blk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    out_seen = 0;
    rdy_mode = 0;
    exp_blk_cnt = 0;
    exp_err = 1'b0;
    bus.pix_in_valid = 1'b0;
    bus.pix_in_data  = '0;
    bus.cpu_ack      = 1'b0;
    bus.blk_from_cpu = '0;
    reset_reset_n    = 1'b0;
    repeat (2) @(negedge clk_clk);
    check("init_req", bus.cpu_req, 0);
    check("init_valid", bus.pix_out_valid, 0);
    check("init_data", bus.pix_out_data, 0);
    check("init_ready", bus.pix_in_ready, 0);
    check("init_status", status, 0);
    check("init_blk", bus.blk_to_cpu, 0);
    reset_reset_n = 1'b1;
    check("ready_pre_edge", bus.pix_in_ready, 0);
    @(negedge clk_clk);
    check("ready_post_edge", bus.pix_in_ready, 1);

    rdy_mode = 0;
    run_block(0, 1'b1, 1'b0, 1'b1, 5);
    rdy_mode = 1;
    run_block(0, 1'b0, 1'b1, 1'b0,
      $urandom_range(0, 8));
    rdy_mode = 2;
    repeat (2)
      run_block(0, 1'b0, 1'b1, 1'b0,
        $urandom_range(0, 8));
    run_block(1, 1'b0, 1'b1, 1'b0, 3);
    run_block(0, 1'b0, 1'b1, 1'b0, 2);
    run_block(2, 1'b0, 1'b1, 1'b0, 0);
    run_block(0, 1'b0, 1'b1, 1'b0, 4);
    rdy_mode = 0;
    run_block(3, 1'b0, 1'b0, 1'b0, 1);
    rdy_mode = 2;
    run_block(0, 1'b0, 1'b1, 1'b0, 2);

    $display("TB_RESULT checks=%0d failures=%0d",
      checks, failures);
    $finish;
  end

endmodule
